// File: rtl/seq_shift_mul_pkg.sv
// Shared constants for the sequential shift-and-add multiplier and its ALU neighbours.
package seq_shift_mul_pkg;

  localparam int DEF_WIDTH = 8;

  localparam logic [3:0] ALU_OP_MUL = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } mul_state_t;

endpackage

// File: rtl/seq_shift_mul.sv
// Unsigned multi-cycle multiplier: one shift-and-add step per clock, WIDTH steps per result,
// with a one-cycle done pulse and a held product/overflow pair.
module seq_shift_mul
  import seq_shift_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_op1,
  input  logic [WIDTH-1:0]   i_op2,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product,
  output logic               o_ovf
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mul_state_t         r_state;
  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_count;
  logic               r_busy;
  logic               r_done;
  logic [2*WIDTH-1:0] r_product;
  logic               r_ovf;

  logic [2*WIDTH-1:0] w_acc_next;

  // The multiplier is shifted right each step, so bit 0 is always the current bit i.
  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc     <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_product <= '0;
      r_ovf     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_op1};
            r_mplier <= i_op2;
            r_acc    <= '0;
            r_count  <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_count  <= r_count + 1'b1;
          if (r_count == LAST_CNT) begin
            r_product <= w_acc_next;
            r_ovf     <= |w_acc_next[2*WIDTH-1:WIDTH];
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= ST_DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_product = r_product;
  assign o_ovf     = r_ovf;

endmodule

// File: tb/tb_seq_shift_mul.sv
// Self-checking bench for seq_shift_mul: directed boundary cases plus random operands,
// checked against plain integer multiplication.
module tb_seq_shift_mul;

  localparam int W = 8;
  localparam int TIMEOUT = 40;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   op1;
  logic [W-1:0]   op2;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
  logic           ovf;

  int n_cmp = 0;
  int n_err = 0;
  logic [2*W-1:0] held_product;
  logic           held_ovf;

  seq_shift_mul #(.WIDTH(W)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_op1     (op1),
    .i_op2     (op2),
    .o_busy    (busy),
    .o_done    (done),
    .o_product (product),
    .o_ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: the product is just a*b; overflow means it exceeds W bits.
  function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
    int unsigned p;
    p = int'(a) * int'(b);
    return (2*W)'(p);
  endfunction

  // Count edges from acceptance until done; returns the observed latency and busy-cycle count.
  task automatic wait_done(input int disturb, output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = 0;
    while (!done && lat < TIMEOUT) begin
      if (busy) busy_cnt++;
      if (disturb != 0) begin
        op1 = 8'(($urandom_range(0, 255)));
        op2 = 8'(($urandom_range(0, 255)));
        if (lat + 1 == 2 || lat + 1 == 5) begin
          start = 1'b1;
          op1 = 8'hFF;
          op2 = 8'hFF;
        end else begin
          start = 1'b0;
        end
      end
      tick();
      lat++;
    end
    start = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int disturb);
    int lat;
    int bc;
    logic [2*W-1:0] exp_p;
    exp_p = ref_prod(a, b);
    op1 = a;
    op2 = b;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    chk("product_held", 32'(product), 32'(held_product));
    wait_done(disturb, lat, bc);
    chk("latency", 32'(lat), 32'(W));
    chk("busy_cycles", 32'(bc), 32'(W));
    chk("done", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("product", 32'(product), 32'(exp_p));
    chk("ovf", 32'(ovf), 32'(exp_p[2*W-1:W] != 0));
    $display("op %02h*%02h -> product=%04h ovf=%0b lat=%0d", a, b, product, ovf, lat);
    held_product = exp_p;
    held_ovf = (exp_p[2*W-1:W] != 0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("product_after_done", 32'(product), 32'(exp_p));
  endtask

  initial begin
    int lat;
    int bc;
    int seen;
    rst = 1'b1;
    start = 1'b1;
    op1 = 8'h12;
    op2 = 8'h34;
    tick();
    tick();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    chk("reset_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    held_product = '0;
    held_ovf = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    run_op(8'h0E, 8'h02, 0);
    run_op(8'hAB, 8'h02, 0);
    run_op(8'hFF, 8'hFF, 0);
    run_op(8'h00, 8'h5A, 0);
    run_op(8'h37, 8'h01, 0);
    run_op(8'h5A, 8'h00, 0);

    // Starts and operand changes while busy must not disturb the captured operation.
    run_op(8'h05, 8'h03, 1);
    tick();
    chk("no_extra_done", 32'(done), 32'd0);
    chk("no_extra_busy", 32'(busy), 32'd0);

    // Reset in the middle of RUN aborts with no done.
    op1 = 8'h10;
    op2 = 8'h10;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    seen = 0;
    for (int i = 0; i < 2 * W; i++) begin
      if (done) seen++;
      tick();
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    held_product = '0;
    held_ovf = 1'b0;
    run_op(8'h10, 8'h10, 0);

    // Back-to-back: start held through DONE launches the next operation immediately.
    op1 = 8'h03;
    op2 = 8'h04;
    start = 1'b1;
    tick();
    op1 = 8'h02;
    op2 = 8'h02;
    lat = 0;
    while (!done && lat < TIMEOUT) begin
      tick();
      lat++;
    end
    chk("b2b_first_latency", 32'(lat), 32'(W));
    chk("b2b_first_product", 32'(product), 32'h000C);
    $display("op 03*04 -> product=%04h ovf=%0b lat=%0d", product, ovf, lat);
    tick();
    start = 1'b0;
    chk("b2b_relaunch_busy", 32'(busy), 32'd1);
    chk("b2b_relaunch_done", 32'(done), 32'd0);
    wait_done(0, lat, bc);
    chk("b2b_second_latency", 32'(lat), 32'(W));
    chk("b2b_second_product", 32'(product), 32'h0004);
    chk("b2b_second_ovf", 32'(ovf), 32'd0);
    $display("op 02*02 -> product=%04h ovf=%0b lat=%0d", product, ovf, lat);
    held_product = 16'h0004;
    held_ovf = 1'b0;
    tick();

    for (int n = 0; n < 24; n++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (n % 8 == 3) a = 8'hFF;
      if (n % 8 == 5) b = 8'h00;
      if (n % 8 == 6) b = 8'h01;
      run_op(a, b, n % 4 == 1 ? 1 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_shift_mul.md
Name: seq_shift_mul

Overview:
- Multi-cycle unsigned shift-and-add multiplier. It is the multiply-side counterpart of the CPU's divide-by-2 shifter.
- Used by the ALU execute stage for MUL-class instructions.
- Accepts two WIDTH-bit operands on a start pulse and returns a 2*WIDTH-bit product with a one-cycle done pulse after a fixed latency.
- Provides an overflow flag, the analogue of the shifter's cout: set when the product does not fit in WIDTH bits.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- op1  input  WIDTH  multiplicand; captured on an accepted start.
- op2  input  WIDTH  multiplier; captured on an accepted start.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse; product and ovf are valid in this cycle.
- product  output  2*WIDTH  unsigned op1*op2; held after done until the next accepted start.
- ovf  output  1  1 when product[2*WIDTH-1:WIDTH] != 0; held alongside product.

Behaviour:
- States: IDLE, RUN, DONE.
- Reset (sync, rst=1 at a clk edge):
  - state=IDLE; busy=0, done=0, product=0, ovf=0; internal count and registers cleared.
  - rst overrides start in the same cycle.
  - rst during RUN aborts the operation; no done is produced.
- Accept rule: start=1 at an edge while state is IDLE or DONE.
  - Captures op1/op2, clears the accumulator, count=0, goes to RUN; busy=1 from the next cycle.
  - product/ovf keep their old values until the new result is written.
- RUN: one iteration per clock edge, exactly WIDTH iterations.
  - Iteration i (i=0..WIDTH-1): if multiplier bit i = 1, accumulator += multiplicand << i.
  - Accumulator is 2*WIDTH bits and cannot overflow.
  - count increments 0..WIDTH-1. On the edge completing iteration WIDTH-1: product<=accumulator, ovf<=|accumulator[2W-1:W], state=DONE.
  - start while busy=1 is ignored (not queued).
- DONE: done=1 and busy=0 for exactly one cycle.
  - Next edge: start=1 → RUN (back-to-back, done drops); otherwise → IDLE.
- Latency: start accepted at edge k → done=1 in the cycle after edge k+WIDTH. Fixed, independent of operand values; no early termination on zero operands.
- Throughput: one result per WIDTH+1 cycles with back-to-back starts.
- Inputs op1/op2 may change freely after acceptance; the result depends only on the values captured at acceptance.
- Boundaries:
  - 0*x and x*0 → product=0, ovf=0, same latency.
  - max*max → product = (2^W-1)^2, ovf=1.
  - Multiply by 1 → product = op1, ovf=0.
  - Illegal state encoding → IDLE.

Decomposition:
- Shared package holds:
  - State encoding constants (IDLE/RUN/DONE).
  - Default operand width constant (8), shared with the existing shifters.
  - ALU op-code constant for MUL.
- Counter width is clog2(WIDTH)+1, derived locally.
- No sub-module: datapath (one adder, shift, counter) and FSM are small enough for one module.

Test Plan:
- Reset then op1=8'h0E, op2=8'h02, one-cycle start → busy high 8 cycles; done pulse 9 edges after start; product=16'h001C, ovf=0.
- op1=8'hAB, op2=8'h02 → product=16'h0156, ovf=1. op1=8'hFF, op2=8'hFF → product=16'hFE01, ovf=1.
- op1=8'h00, op2=8'h5A, and op1=8'h37, op2=8'h01 → product=0/ovf=0 and product=16'h0037/ovf=0, each with identical 9-edge latency.
- Start 3'h5*3'h3 (8-bit 8'h05*8'h03), then pulse start with 8'hFF*8'hFF at cycles 2 and 5 of RUN → ignored; single done, product=16'h000F. Change op1/op2 mid-RUN → result unchanged.
- Start 8'h10*8'h10, assert rst at RUN cycle 4 → busy=0, done never pulses, product=0, ovf=0. Next start 8'h10*8'h10 → product=16'h0100, ovf=1.
- Hold start high through DONE after 8'h03*8'h04 with new operands 8'h02*8'h02 → first done with 16'h000C, immediately RUN again; second done WIDTH+1 edges later with 16'h0004.
